// File: rtl/rf_corr_pkg.sv
// -----------------------------------------------------------------------------
// rf_corr_pkg
//   Shared defaults and helpers for the RF correlator bank.
//   - CODE_LEN_DEF  : bits per symbol window / reference code
//   - NUM_CODES_DEF : number of programmable reference codes
//   - clog2()       : ceiling log2, used to size index and score fields
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package rf_corr_pkg;

  localparam int CODE_LEN_DEF  = 32'sd32;
  localparam int NUM_CODES_DEF = 32'sd16;

  // Ceiling log2; never returns less than 1 so derived vectors stay legal.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    if (result < 32'sd1) begin
      result = 32'sd1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/corr_score.sv
// -----------------------------------------------------------------------------
// corr_score
//   Combinational agreement score of one symbol window against one code:
//   score = CODE_LEN - popcount(window ^ code), kept at full SCORE_W width.
//   Ports:
//     window : received symbol window
//     code   : reference code
//     score  : number of agreeing bit positions (0..CODE_LEN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module corr_score
  import rf_corr_pkg::*;
#(
  parameter int CODE_LEN = CODE_LEN_DEF,
  parameter int SCORE_W  = clog2(CODE_LEN_DEF + 32'sd1)
) (
  input  logic [CODE_LEN-1:0] window,
  input  logic [CODE_LEN-1:0] code,
  output logic [SCORE_W-1:0]  score
);

  logic [CODE_LEN-1:0] diff_s;
  logic [SCORE_W-1:0]  ones_s;

  // Count disagreeing bits and convert to an agreement count.
  always_comb begin
    diff_s = window ^ code;
    ones_s = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      ones_s = ones_s + SCORE_W'(diff_s[i]);
    end
    score = SCORE_W'(CODE_LEN) - ones_s;
  end

endmodule

// File: rtl/rf_correlator_bank.sv
// -----------------------------------------------------------------------------
// rf_correlator_bank
//   Serial symbol correlator: accumulates CODE_LEN bits (MSB first) into a
//   window, scores it against NUM_CODES programmable reference codes and
//   reports the best match (ties -> lowest index) through a valid/ready
//   output register. Result appears two cycles after the completing bit.
//
//   Ports:
//     Clock, Reset_n          : rising-edge clock, async active-low reset
//     Bit_valid, Bit_stream   : serial bit input, sampled when Bit_valid=1
//     Sync                    : realign symbol boundary (a bit accepted in the
//                               same cycle becomes bit 0 of the new symbol)
//     Code_wr_en/addr/data    : reference code write port
//     Out_ready               : consumer accepts held result
//     Out_valid/idx/score     : best-match result, held until accepted
//     Overrun                 : sticky, an unconsumed result was overwritten
//
//   Build option RF_CORR_THRESH_EN adds input Thresh and output Out_hit
//   (Out_hit = Out_score >= Thresh, registered with the result).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rf_correlator_bank
  import rf_corr_pkg::*;
#(
  parameter  int CODE_LEN  = CODE_LEN_DEF,
  parameter  int NUM_CODES = NUM_CODES_DEF,
  localparam int IDX_W     = clog2(NUM_CODES),
  localparam int SCORE_W   = clog2(CODE_LEN + 32'sd1)
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Bit_valid,
  input  logic                Bit_stream,
  input  logic                Sync,
  input  logic                Code_wr_en,
  input  logic [IDX_W-1:0]    Code_wr_addr,
  input  logic [CODE_LEN-1:0] Code_wr_data,
  input  logic                Out_ready,
  output logic                Out_valid,
  output logic [IDX_W-1:0]    Out_idx,
  output logic [SCORE_W-1:0]  Out_score,
`ifdef RF_CORR_THRESH_EN
  input  logic [SCORE_W-1:0]  Thresh,
  output logic                Out_hit,
`endif
  output logic                Overrun
);

  localparam int CNT_W = clog2(CODE_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_LEN - 32'sd1);

  // Only the newest CODE_LEN-1 bits are kept; the completing bit is taken
  // straight from Bit_stream to form the full window.
  logic [CODE_LEN-2:0]  shift_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [CODE_LEN-1:0]  code_r [NUM_CODES];

  logic [CODE_LEN-1:0]  window_s;
  logic                 sym_done_s;
  logic [SCORE_W-1:0]   score_s    [NUM_CODES];
  logic [SCORE_W-1:0]   s1_score_r [NUM_CODES];
  logic                 s1_valid_r;

  logic [IDX_W-1:0]     best_idx_s;
  logic [SCORE_W-1:0]   best_score_s;

  logic                 out_valid_r;
  logic [IDX_W-1:0]     out_idx_r;
  logic [SCORE_W-1:0]   out_score_r;
  logic                 overrun_r;
`ifdef RF_CORR_THRESH_EN
  logic                 out_hit_r;
`endif

  // Window assembly and symbol-completion detect (Sync wins over completion).
  always_comb begin
    window_s   = {shift_r, Bit_stream};
    sym_done_s = Bit_valid & ~Sync & (cnt_r == LAST_CNT);
  end

  // Serial shift register and modulo-CODE_LEN bit counter.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_r <= '0;
      cnt_r   <= '0;
    end else begin
      if (Bit_valid) begin
        shift_r <= window_s[CODE_LEN-2:0];
      end
      if (Sync) begin
        cnt_r <= Bit_valid ? CNT_W'(1) : CNT_W'(0);
      end else if (Bit_valid) begin
        cnt_r <= (cnt_r == LAST_CNT) ? CNT_W'(0) : cnt_r + CNT_W'(1);
      end
    end
  end

  // Reference code storage; scores this cycle still see the pre-write code.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        code_r[i] <= '0;
      end
    end else if (Code_wr_en) begin
      code_r[Code_wr_addr] <= Code_wr_data;
    end
  end

  genvar g;
  for (g = 0; g < NUM_CODES; g++) begin : g_score
    corr_score #(
      .CODE_LEN (CODE_LEN),
      .SCORE_W  (SCORE_W)
    ) u_score (
      .window (window_s),
      .code   (code_r[g]),
      .score  (score_s[g])
    );
  end

  // Stage 1: capture all scores of a completed window.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_r <= 1'b0;
      for (int i = 0; i < NUM_CODES; i++) begin
        s1_score_r[i] <= '0;
      end
    end else begin
      s1_valid_r <= sym_done_s;
      if (sym_done_s) begin
        for (int i = 0; i < NUM_CODES; i++) begin
          s1_score_r[i] <= score_s[i];
        end
      end
    end
  end

  // Best-score search; strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx_s   = '0;
    best_score_s = s1_score_r[0];
    for (int i = 1; i < NUM_CODES; i++) begin
      if (s1_score_r[i] > best_score_s) begin
        best_idx_s   = IDX_W'(i);
        best_score_s = s1_score_r[i];
      end else begin
        best_score_s = best_score_s;
      end
    end
  end

  // Stage 2: output hold register with valid/ready handshake and overrun.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= '0;
      out_score_r <= '0;
      overrun_r   <= 1'b0;
`ifdef RF_CORR_THRESH_EN
      out_hit_r   <= 1'b0;
`endif
    end else begin
      if (s1_valid_r) begin
        out_valid_r <= 1'b1;
        out_idx_r   <= best_idx_s;
        out_score_r <= best_score_s;
`ifdef RF_CORR_THRESH_EN
        out_hit_r   <= (best_score_s >= Thresh);
`endif
        if (out_valid_r && !Out_ready) begin
          overrun_r <= 1'b1;
        end
      end else if (out_valid_r && Out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign Out_valid = out_valid_r;
  assign Out_idx   = out_idx_r;
  assign Out_score = out_score_r;
  assign Overrun   = overrun_r;
`ifdef RF_CORR_THRESH_EN
  assign Out_hit   = out_hit_r;
`endif

endmodule
